// File: rtl/marc_ctrl_pkg.sv
// Shared control definitions for the multicycle core's control unit.
// Provides the one-hot state bit indices, instruction class encodings,
// the multiply function code and small helpers for one-hot state vectors.
// Used by the sequencer, the opcode classifier and trace/disassembly tools.
package marc_ctrl_pkg;

  localparam int NSTATES = 14;

  // Bit index of each state inside the one-hot state vector.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_OPF_ALU   = 4'd2,
    S_EX_ALU    = 4'd3,
    S_OPF_MEM   = 4'd4,
    S_EX_MEM    = 4'd5,
    S_OPF_JMP   = 4'd6,
    S_EX_JMP    = 4'd7,
    S_OPF_SET   = 4'd8,
    S_EX_SET    = 4'd9,
    S_LINK      = 4'd10,
    S_LINK_CALL = 4'd11,
    S_UPD_PC    = 4'd12,
    S_HALT      = 4'd13
  } state_idx_e;

  // Instruction class as decided from the IR format/function fields.
  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_MEM  = 3'd1,
    CLS_JMP  = 3'd2,
    CLS_SET  = 3'd3,
    CLS_LINK = 3'd4
  } opc_class_e;

  localparam logic [3:0] OPC_MUL = 4'b1000;

  // One-hot vector with only the bit for the given state set.
  function automatic logic [NSTATES-1:0] onehot_of(input state_idx_e idx);
    return NSTATES'(1) << idx;
  endfunction

  // True when exactly one bit of the state vector is set.
  function automatic logic is_onehot(input logic [NSTATES-1:0] v);
    return (v != '0) && ((v & (v - NSTATES'(1))) == '0);
  endfunction

endpackage

// File: rtl/instr_sequencer_opc_classifier.sv
// opc_classifier: combinational instruction classifier.
// Maps the IR format bit and function field onto an instruction class and
// flags the multiply function.
// Ports:
//   opc1   in  IR format bit (1 = link/call format)
//   opc2   in  IR function field
//   cls    out instruction class
//   is_mul out multiply instruction (ALU format, function OPC_MUL)
module opc_classifier
  import marc_ctrl_pkg::*;
(
  input  logic       opc1,
  input  logic [3:0] opc2,
  output opc_class_e cls,
  output logic       is_mul
);

  // Class decode; unlisted function codes fall back to plain ALU ops.
  always_comb begin
    cls = CLS_ALU;
    if (opc1) begin
      cls = CLS_LINK;
    end else begin
      case (opc2)
        4'b0110, 4'b0111: cls = CLS_MEM;
        4'b1001:          cls = CLS_JMP;
        4'b1010, 4'b1011: cls = CLS_SET;
        default:          cls = CLS_ALU;
      endcase
    end
  end

  assign is_mul = ~opc1 & (opc2 == OPC_MUL);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: clocked control sequencer of the multicycle core.
// Holds the one-hot control state and stalls on memory, multiplier and
// halt/resume handshakes; drives the datapath strobes, a sticky memory
// timeout error and a retired-instruction counter.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset
//   opc1      in  IR format bit (sampled in DECODE)
//   opc2      in  IR function field (sampled in DECODE)
//   mem_ack   in  memory completes current request
//   mul_done  in  multiplier result valid
//   halt_req  in  stop at next instruction boundary
//   run       in  resume from HALT
//   state     out one-hot state vector, bit 13 = HALT
//   mem_req   out memory request level
//   ir_load   out load instruction register
//   mul_start out one-cycle multiplier start pulse
//   pc_load   out update program counter
//   halted    out core is in HALT
//   bus_err   out sticky memory timeout flag
//   retired   out retired-instruction count
module instr_sequencer
  import marc_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               opc1,
  input  logic [3:0]         opc2,
  input  logic               mem_ack,
  input  logic               mul_done,
  input  logic               halt_req,
  input  logic               run,
  output logic [NSTATES-1:0] state,
  output logic               mem_req,
  output logic               ir_load,
  output logic               mul_start,
  output logic               pc_load,
  output logic               halted,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired
);

  // Counter value in the last wait cycle before a timeout is declared:
  // the counter reaches MEM_TIMEOUT on the same edge that moves to HALT.
  localparam logic [TO_W-1:0] TMO_LAST = TO_W'(MEM_TIMEOUT - 1);

  opc_class_e         dec_cls;
  logic               dec_is_mul;
  opc_class_e         cls_q;
  logic               is_mul_q;
  logic               mul_fired;
  logic [TO_W-1:0]    tmo_cnt;
  logic [NSTATES-1:0] state_next;
  logic               legal;
  logic               wait_cycle;
  logic               tmo_expire;
  logic               tmo_clear;
  logic               mul_active;

  opc_classifier u_classifier (
    .opc1   (opc1),
    .opc2   (opc2),
    .cls    (dec_cls),
    .is_mul (dec_is_mul)
  );

  assign mem_req    = state[S_FETCH] | state[S_EX_MEM];
  assign ir_load    = state[S_FETCH] & mem_ack;
  assign pc_load    = state[S_UPD_PC];
  assign halted     = state[S_HALT];
  assign mul_active = is_mul_q & (cls_q == CLS_ALU);
  // mul_fired is low only in the first EX_ALU cycle of an instruction.
  assign mul_start  = state[S_EX_ALU] & mul_active & ~mul_fired;

  // Next-state function, timeout detection and timeout-counter clear.
  always_comb begin
    state_next = onehot_of(S_FETCH);
    legal      = is_onehot(state);
    wait_cycle = mem_req & ~mem_ack;
    tmo_expire = wait_cycle & (tmo_cnt == TMO_LAST);
    tmo_clear  = 1'b0;
    if (!legal) begin
      state_next = onehot_of(S_FETCH);
    end else begin
      case (1'b1)
        state[S_FETCH]: begin
          if (mem_ack) begin
            state_next = onehot_of(S_DECODE);
          end else if (tmo_expire) begin
            state_next = onehot_of(S_HALT);
          end else begin
            state_next = onehot_of(S_FETCH);
          end
        end
        state[S_DECODE]: begin
          case (dec_cls)
            CLS_MEM:  state_next = onehot_of(S_OPF_MEM);
            CLS_JMP:  state_next = onehot_of(S_OPF_JMP);
            CLS_SET:  state_next = onehot_of(S_OPF_SET);
            CLS_LINK: state_next = onehot_of(S_LINK);
            default:  state_next = onehot_of(S_OPF_ALU);
          endcase
        end
        state[S_OPF_ALU]: state_next = onehot_of(S_EX_ALU);
        state[S_EX_ALU]: begin
          if (mul_active && !mul_done) begin
            state_next = onehot_of(S_EX_ALU);
          end else begin
            state_next = onehot_of(S_UPD_PC);
          end
        end
        state[S_OPF_MEM]: state_next = onehot_of(S_EX_MEM);
        state[S_EX_MEM]: begin
          if (mem_ack) begin
            state_next = onehot_of(S_UPD_PC);
          end else if (tmo_expire) begin
            state_next = onehot_of(S_HALT);
          end else begin
            state_next = onehot_of(S_EX_MEM);
          end
        end
        state[S_OPF_JMP]:   state_next = onehot_of(S_EX_JMP);
        state[S_EX_JMP]:    state_next = onehot_of(S_UPD_PC);
        state[S_OPF_SET]:   state_next = onehot_of(S_EX_SET);
        state[S_EX_SET]:    state_next = onehot_of(S_UPD_PC);
        state[S_LINK]:      state_next = onehot_of(S_LINK_CALL);
        state[S_LINK_CALL]: state_next = onehot_of(S_UPD_PC);
        state[S_UPD_PC]: begin
          if (halt_req) begin
            state_next = onehot_of(S_HALT);
          end else begin
            state_next = onehot_of(S_FETCH);
          end
        end
        state[S_HALT]: begin
          if (run) begin
            state_next = onehot_of(S_FETCH);
          end else begin
            state_next = onehot_of(S_HALT);
          end
        end
        default: state_next = onehot_of(S_FETCH);
      endcase
      // The wait budget restarts whenever a memory-waiting state is entered.
      tmo_clear = (state_next[S_FETCH]  & ~state[S_FETCH]) |
                  (state_next[S_EX_MEM] & ~state[S_EX_MEM]);
    end
  end

  // State register and decode results latched in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= onehot_of(S_FETCH);
      cls_q    <= CLS_ALU;
      is_mul_q <= 1'b0;
    end else begin
      state <= state_next;
      if (legal && state[S_DECODE]) begin
        cls_q    <= dec_cls;
        is_mul_q <= dec_is_mul;
      end
    end
  end

  // Multiply start tracking: set while staying in EX_ALU, re-armed on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_fired <= 1'b0;
    end else begin
      mul_fired <= state[S_EX_ALU] & state_next[S_EX_ALU];
    end
  end

  // Memory wait counter and sticky bus error; frozen in an illegal state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else if (legal) begin
      if (tmo_clear) begin
        tmo_cnt <= '0;
      end else if (wait_cycle) begin
        tmo_cnt <= tmo_cnt + TO_W'(1);
      end
      if (tmo_expire) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Retired-instruction counter, advanced once per UPD_PC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (legal && state[S_UPD_PC]) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the stimulus process drives one
// directed vector per cycle and queues the hand-computed expected outputs;
// the monitor pops and compares one entry per falling clock edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        opc1;
  logic [3:0]  opc2;
  logic        mem_ack;
  logic        mul_done;
  logic        halt_req;
  logic        run;
  logic [13:0] state;
  logic        mem_req;
  logic        ir_load;
  logic        mul_start;
  logic        pc_load;
  logic        halted;
  logic        bus_err;
  logic [31:0] retired;

  typedef struct {
    string       name;
    logic [13:0] st;
    logic [3:0]  strb;   // {mem_req, ir_load, mul_start, pc_load}
    logic        berr;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opc1      (opc1),
    .opc2      (opc2),
    .mem_ack   (mem_ack),
    .mul_done  (mul_done),
    .halt_req  (halt_req),
    .run       (run),
    .state     (state),
    .mem_req   (mem_req),
    .ir_load   (ir_load),
    .mul_start (mul_start),
    .pc_load   (pc_load),
    .halted    (halted),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act_strb;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_strb = {mem_req, ir_load, mul_start, pc_load};
      vectors++;
      if ((state !== e.st) || (act_strb !== e.strb) || (halted !== e.st[13]) ||
          (bus_err !== e.berr) || (retired !== e.ret)) begin
        miscompares++;
        $display("FAIL %s (vec %0d): got st=%h strb=%b halted=%b berr=%b ret=%0d, want st=%h strb=%b halted=%b berr=%b ret=%0d",
                 e.name, vectors, state, act_strb, halted, bus_err, retired,
                 e.st, e.strb, e.st[13], e.berr, e.ret);
      end
    end
  end

  // One cycle: apply handshake inputs, queue the expected outputs.
  task automatic v(input string nm, input logic a, input logic md,
                   input logic hr, input logic rn, input logic [13:0] st,
                   input logic [3:0] sb, input logic be, input logic [31:0] rt);
    exp_t e;
    mem_ack  = a;
    mul_done = md;
    halt_req = hr;
    run      = rn;
    e.name = nm;
    e.st   = st;
    e.strb = sb;
    e.berr = be;
    e.ret  = rt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Present a corrupt (two-hot) state for one cycle while in FETCH.
  task automatic illegal_cycle(input logic [31:0] rt);
    exp_t e;
    mem_ack  = 1'b0;
    mul_done = 1'b0;
    halt_req = 1'b0;
    run      = 1'b0;
    force dut.state = 14'h0005;
    e.name = "illegal_state";
    e.st   = 14'h0005;
    e.strb = 4'b1000;
    e.berr = 1'b0;
    e.ret  = rt;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    release dut.state;
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run is a few thousand cycles at most.
  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: stimulus did not complete, got timeout, want finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1'b1; opc1 = 1'b0; opc2 = 4'b0000;
    mem_ack = 1'b0; mul_done = 1'b0; halt_req = 1'b0; run = 1'b0;
    @(posedge clk);
    #1;
    v("reset", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1000, 1'b0, 32'd0);
    rst = 1'b0;

    // Plain ALU op, memory always ready.
    opc1 = 1'b0; opc2 = 4'b0001;
    v("alu_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd0);
    v("alu_decode", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd0);
    v("alu_opf",    1'b1, 1'b0, 1'b0, 1'b0, 14'h0004, 4'b0000, 1'b0, 32'd0);
    v("alu_ex",     1'b1, 1'b0, 1'b0, 1'b0, 14'h0008, 4'b0000, 1'b0, 32'd0);
    v("alu_updpc",  1'b1, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd0);

    // Multiply, done four cycles after start.
    opc2 = 4'b1000;
    v("mul_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd1);
    v("mul_decode", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd1);
    v("mul_opf",    1'b1, 1'b0, 1'b0, 1'b0, 14'h0004, 4'b0000, 1'b0, 32'd1);
    v("mul_start",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0008, 4'b0010, 1'b0, 32'd1);
    for (int i = 0; i < 3; i++)
      v("mul_wait", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0008, 4'b0000, 1'b0, 32'd1);
    v("mul_done",   1'b1, 1'b1, 1'b0, 1'b0, 14'h0008, 4'b0000, 1'b0, 32'd1);
    v("mul_updpc",  1'b1, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd1);

    // Load/store with three wait cycles in EX_MEM.
    opc2 = 4'b0110;
    v("mem_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd2);
    v("mem_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd2);
    v("mem_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0010, 4'b0000, 1'b0, 32'd2);
    for (int i = 0; i < 3; i++)
      v("mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b0, 32'd2);
    v("mem_ack",    1'b1, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b0, 32'd2);
    v("mem_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd2);

    // Link/call with halt request at the boundary, then resume.
    opc1 = 1'b1;
    v("lnk_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd3);
    v("lnk_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd3);
    v("lnk_link",   1'b0, 1'b0, 1'b0, 1'b0, 14'h0400, 4'b0000, 1'b0, 32'd3);
    v("lnk_call",   1'b0, 1'b0, 1'b0, 1'b0, 14'h0800, 4'b0000, 1'b0, 32'd3);
    v("lnk_updpc",  1'b0, 1'b0, 1'b1, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd3);
    v("lnk_halt",   1'b0, 1'b0, 1'b1, 1'b0, 14'h2000, 4'b0000, 1'b0, 32'd4);
    v("lnk_run",    1'b0, 1'b0, 1'b0, 1'b1, 14'h2000, 4'b0000, 1'b0, 32'd4);

    // Fetch never acknowledged: 255 wait cycles, then bus error and HALT.
    opc1 = 1'b0; opc2 = 4'b0001;
    for (int i = 0; i < 255; i++)
      v("tmo_wait", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1000, 1'b0, 32'd4);
    v("tmo_halt",   1'b0, 1'b0, 1'b0, 1'b0, 14'h2000, 4'b0000, 1'b1, 32'd4);
    v("tmo_run",    1'b0, 1'b0, 1'b0, 1'b1, 14'h2000, 4'b0000, 1'b1, 32'd4);

    // Resume with sticky error, then reset in the middle of EX_MEM.
    opc2 = 4'b0110;
    v("rst_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b1, 32'd4);
    v("rst_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b1, 32'd4);
    v("rst_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0010, 4'b0000, 1'b1, 32'd4);
    v("rst_wait",   1'b0, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b1, 32'd4);
    rst = 1'b1;
    v("rst_assert", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b1, 32'd4);
    rst = 1'b0;
    opc2 = 4'b0001;
    v("rst_after",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd0);
    v("ill_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd0);
    v("ill_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0004, 4'b0000, 1'b0, 32'd0);
    v("ill_ex",     1'b0, 1'b0, 1'b0, 1'b0, 14'h0008, 4'b0000, 1'b0, 32'd0);
    v("ill_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd0);

    // Corrupt state recovers to FETCH without touching the counters.
    illegal_cycle(32'd1);
    v("ill_recover", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1000, 1'b0, 32'd1);

    // Jump and set classes.
    opc2 = 4'b1001;
    v("jmp_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd1);
    v("jmp_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd1);
    v("jmp_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0040, 4'b0000, 1'b0, 32'd1);
    v("jmp_ex",     1'b0, 1'b0, 1'b0, 1'b0, 14'h0080, 4'b0000, 1'b0, 32'd1);
    v("jmp_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd1);
    opc2 = 4'b1011;
    v("set_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd2);
    v("set_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd2);
    v("set_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0100, 4'b0000, 1'b0, 32'd2);
    v("set_ex",     1'b0, 1'b0, 1'b0, 1'b0, 14'h0200, 4'b0000, 1'b0, 32'd2);
    v("set_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd2);

    // Single-cycle multiply: mul_done together with mul_start.
    opc2 = 4'b1000;
    v("mul1_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd3);
    v("mul1_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd3);
    v("mul1_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0004, 4'b0000, 1'b0, 32'd3);
    v("mul1_ex",     1'b0, 1'b1, 1'b0, 1'b0, 14'h0008, 4'b0010, 1'b0, 32'd3);
    v("mul1_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd3);

    // Memory ack arrives in the very cycle the timeout would expire.
    opc2 = 4'b0110;
    v("race_fetch",  1'b1, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1100, 1'b0, 32'd4);
    v("race_decode", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 4'b0000, 1'b0, 32'd4);
    v("race_opf",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0010, 4'b0000, 1'b0, 32'd4);
    for (int i = 0; i < 254; i++)
      v("race_wait", 1'b0, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b0, 32'd4);
    v("race_ack",    1'b1, 1'b0, 1'b0, 1'b0, 14'h0020, 4'b1000, 1'b0, 32'd4);
    v("race_updpc",  1'b0, 1'b0, 1'b0, 1'b0, 14'h1000, 4'b0001, 1'b0, 32'd4);
    v("race_end",    1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 4'b1000, 1'b0, 32'd5);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Clocked control sequencer for the multicycle core.
- Holds the one-hot control state register and adds stall handshakes that a purely combinational next-state function cannot express:
  - memory wait on instruction fetch and on memory instructions;
  - multi-cycle multiply;
  - halt/resume.
- Drives datapath strobes and a retired-instruction counter. Sits in the control unit between the instruction register and the datapath.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 255, max cycles waiting on mem_ack before bus error
- TO_W, 8, width of timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- opc1  in  1  IR format bit; sampled only in DECODE
- opc2  in  4  IR function field; sampled only in DECODE
- mem_ack  in  1  memory completes the current request this cycle
- mul_done  in  1  multiplier result valid this cycle
- halt_req  in  1  request to stop at the next instruction boundary
- run  in  1  resume from HALT
- state  out  14  one-hot state; bits 0..12 as below, bit 13 = HALT
- mem_req  out  1  memory request level
- ir_load  out  1  load IR
- mul_start  out  1  one-cycle multiplier start pulse
- pc_load  out  1  update PC
- halted  out  1  equals state[13]
- bus_err  out  1  sticky; set on memory timeout
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst and overrides everything, including mid-wait.
- Reset values:
  - state = FETCH (bit 0);
  - mem_req = 1 (combinational from state);
  - ir_load, mul_start, pc_load, halted, bus_err = 0;
  - retired = 0;
  - timeout counter = 0;
  - latched class = ALU.
- States: FETCH 0, DECODE 1, OPF_ALU 2, EX_ALU 3, OPF_MEM 4, EX_MEM 5, OPF_JMP 6, EX_JMP 7, OPF_SET 8, EX_SET 9, LINK 10, LINK_CALL 11, UPD_PC 12, HALT 13.
- Decode in DECODE; class and is_mul are registered here, and later states ignore opc1/opc2:
  - opc1 = 1 -> LINK;
  - else opc2 = 011x -> OPF_MEM;
  - 1001 -> OPF_JMP;
  - 101x -> OPF_SET;
  - all other values -> OPF_ALU;
  - is_mul = (opc1 = 0 and opc2 = 1000).
- Transitions:
  - FETCH -> DECODE when mem_ack, else hold.
  - OPF_x -> EX_x unconditionally.
  - EX_ALU: if is_mul, hold until mul_done; otherwise 1 cycle. Then -> UPD_PC.
  - EX_MEM: hold until mem_ack, then -> UPD_PC.
  - EX_JMP, EX_SET, LINK_CALL -> UPD_PC. LINK -> LINK_CALL.
  - UPD_PC -> HALT if halt_req, else -> FETCH.
  - HALT -> FETCH when run; halt_req is ignored in HALT.
- Outputs (combinational from state and inputs, no latency):
  - mem_req = state[0] | state[5];
  - ir_load = state[0] & mem_ack;
  - pc_load = state[12];
  - mul_start = 1 on the first EX_ALU cycle only when is_mul (registered flag, re-armed on leaving EX_ALU).
- Simultaneous events:
  - mem_ack and timeout expiry in the same cycle: ack wins.
  - mul_done in the first EX_ALU cycle is accepted: 1-cycle multiply.
- retired increments by 1 in each UPD_PC cycle and wraps modulo 2^CNT_W.
- Timeout:
  - The counter clears on entering FETCH or EX_MEM and increments each cycle mem_req = 1 and mem_ack = 0.
  - When it reaches MEM_TIMEOUT: bus_err <= 1 and next state = HALT. The instruction is not retired.
  - bus_err clears only on rst. run from HALT with bus_err = 1 still resumes.
- Illegal state: if state is not one-hot (zero or multiple bits set), next state = FETCH. No counter change.

Decomposition:
- Shared package marc_ctrl_pkg:
  - state bit index constants S_FETCH..S_HALT;
  - NSTATES = 14;
  - opcode class encodings CLS_ALU/MEM/JMP/SET/LINK;
  - OPC_MUL = 4'b1000.
- One sub-module, opc_classifier: combinational opc1/opc2 -> class + is_mul. Reused by the disassembler and trace monitor.
- State register, timeout counter and retired counter stay in instr_sequencer.

Test Plan:
- Reset, then opc1=0, opc2=0001, mem_ack high every cycle -> visits states 0,1,2,3,12,0; pc_load for 1 cycle; retired=1 after 5 cycles.
- opc2=1000, mul_done asserted 4 cycles after mul_start -> mul_start 1 cycle; EX_ALU held 5 cycles; then UPD_PC.
- opc2=0110, mem_ack withheld 3 cycles in EX_MEM -> mem_req high 4 cycles, state[5] held; retired increments once.
- mem_ack never asserted in FETCH with MEM_TIMEOUT=255 -> after 255 wait cycles bus_err=1, halted=1, retired unchanged; run -> FETCH with bus_err still 1.
- opc1=1 with halt_req asserted -> path 0,1,10,11,12,13; halted=1; run pulse -> FETCH the next cycle.
- rst asserted mid-EX_MEM, and separately state forced to 0x0005 -> state=0x0001 next cycle; retired cleared only by rst.
